// File: rtl/vpu_pkg.sv
// Shared constants and state encoding for the VPU destination (result write-back) port.
package vpu_pkg;

    localparam int unsigned DST_FIFO_DEPTH  = 4;
    localparam int unsigned SRAM_ADDR_WIDTH = 10;
    localparam int unsigned ELEM_CNT_WIDTH  = 8;
    localparam int unsigned OPERAND_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dst_state_t;

endpackage

// File: rtl/vpu_dst_fifo.sv
// Registered result FIFO for the destination port: full/empty flags, simultaneous push/pop, flush.
module vpu_dst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vpu_dst_port.sv
// Destination port: buffers FP results and writes them to SRAM at consecutive addresses.
// Define VPU_DST_OVERFLOW_CHK_EN to build the sticky overflow_o flag; otherwise it is tied 0.
module vpu_dst_port
    import vpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DST_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = SRAM_ADDR_WIDTH,
    parameter int unsigned CNT_W      = ELEM_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        dst_addr_i,
    input  logic [CNT_W-1:0]         elem_cnt_i,
    input  logic [OPERAND_WIDTH-1:0] result_i,
    input  logic                     result_valid_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [OPERAND_WIDTH-1:0] wr_data_o,
    input  logic                     wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o
);
    dst_state_t         state_q;
    dst_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   acc_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               start_acc;
    logic               push;
    logic               wr_accept;
    logic               last_write;

    assign start_acc  = (state_q == IDLE) && start_i;
    assign push       = (state_q == RUN) && result_valid_i;
    assign wr_en_o    = (state_q == RUN) && !fifo_empty;
    assign wr_accept  = wr_en_o && wr_ready_i;
    assign last_write = wr_accept && ((acc_q + CNT_W'(1)) == cnt_q);
    assign wr_addr_o  = addr_q;
    assign busy_o     = (state_q == RUN) || (state_q == DONE);
    assign done_o     = (state_q == DONE);

    // Leftover results beyond the job count are discarded while leaving DONE.
    vpu_dst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OPERAND_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (result_i),
        .pop       (wr_accept),
        .flush     (state_q == DONE),
        .head      (wr_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (elem_cnt_i == '0) ? DONE : RUN;
            RUN:     if (last_write) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                cnt_q  <= elem_cnt_i;
                acc_q  <= '0;
                addr_q <= dst_addr_i;
            end else if (wr_accept) begin
                acc_q  <= acc_q + CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

`ifdef VPU_DST_OVERFLOW_CHK_EN
    logic overflow_q;
    logic drop;

    assign drop       = push && fifo_full && !wr_accept;
    assign overflow_o = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         overflow_q <= 1'b0;
        else if (start_acc) overflow_q <= 1'b0;
        else if (drop)      overflow_q <= 1'b1;
    end
`else
    assign overflow_o = 1'b0;
    logic unused_full;
    assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_vpu_dst_port.sv
// Directed self-checking bench for vpu_dst_port; accepted SRAM writes are logged and compared
// against hand-built expected address/data lists.
module tb_vpu_dst_port;
    import vpu_pkg::*;

`ifdef VPU_DST_OVERFLOW_CHK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start_i;
    logic [SRAM_ADDR_WIDTH-1:0] dst_addr_i;
    logic [ELEM_CNT_WIDTH-1:0]  elem_cnt_i;
    logic [OPERAND_WIDTH-1:0]   result_i;
    logic                       result_valid_i;
    logic                       wr_en_o;
    logic [SRAM_ADDR_WIDTH-1:0] wr_addr_o;
    logic [OPERAND_WIDTH-1:0]   wr_data_o;
    logic                       wr_ready_i;
    logic                       busy_o;
    logic                       done_o;
    logic                       overflow_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    vpu_dst_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .dst_addr_i     (dst_addr_i),
        .elem_cnt_i     (elem_cnt_i),
        .result_i       (result_i),
        .result_valid_i (result_valid_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_ready_i     (wr_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    // Inputs change just after a rising edge, so a request seen on the falling edge is accepted next.
    always @(negedge clk) begin
        if (rst_n && wr_en_o && wr_ready_i) begin
            log_addr.push_back(32'(wr_addr_o));
            log_data.push_back(wr_data_o);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [SRAM_ADDR_WIDTH-1:0] dst,
                                 input logic [ELEM_CNT_WIDTH-1:0] cnt, input logic [31:0] res,
                                 input logic rv, input logic rdy);
        start_i        = st;
        dst_addr_i     = dst;
        elem_cnt_i     = cnt;
        result_i       = res;
        result_valid_i = rv;
        wr_ready_i     = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, '0, '0, 32'h0, 1'b0, rdy);
    endtask

    task automatic waitDone(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idleCycle(1'b1);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic checkLog(input string tag);
        int n;
        checkOutput({tag, "_count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
        n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
        end
        log_addr.delete();
        log_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0; dst_addr_i = '0; elem_cnt_i = '0;
        result_i = '0; result_valid_i = 1'b0; wr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_addr", 32'(wr_addr_o), 32'd0);
        checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
        rst_n = 1'b1;
        idleCycle(1'b1);
        checkOutput("post_rst_wr_en", 32'(wr_en_o), 32'd0);

        // Basic job: three results back-to-back with the SRAM always ready.
        applyStimulus(1'b1, 10'h010, 8'd3, 32'h0, 1'b0, 1'b1);
        checkOutput("t1_busy", 32'(busy_o), 32'd1);
        checkOutput("t1_wr_en_idle", 32'(wr_en_o), 32'd0);
        applyStimulus(1'b0, '0, '0, 32'h3F80_0000, 1'b1, 1'b1);
        checkOutput("t1_latency_wr_en", 32'(wr_en_o), 32'd1);
        applyStimulus(1'b0, '0, '0, 32'h4000_0000, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 32'h4040_0000, 1'b1, 1'b1);
        idleCycle(1'b1);
        checkOutput("t1_done", 32'(done_o), 32'd1);
        checkOutput("t1_wr_en_done", 32'(wr_en_o), 32'd0);
        idleCycle(1'b1);
        checkOutput("t1_done_pulse", 32'(done_o), 32'd0);
        checkOutput("t1_busy_after", 32'(busy_o), 32'd0);
        expectWrite(32'h010, 32'h3F80_0000);
        expectWrite(32'h011, 32'h4000_0000);
        expectWrite(32'h012, 32'h4040_0000);
        checkLog("t1");

        // Stalled SRAM: request must hold steady, fifth result overflows the four-entry buffer.
        applyStimulus(1'b1, 10'h020, 8'd5, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, '0, 32'hA0 + 32'(i / 2), (i % 2) == 0, 1'b0);
            checkOutput($sformatf("t2_hold_en%0d", i), 32'(wr_en_o), 32'd1);
            checkOutput($sformatf("t2_hold_addr%0d", i), 32'(wr_addr_o), 32'h020);
            checkOutput($sformatf("t2_hold_data%0d", i), wr_data_o, 32'hA0);
        end
        checkOutput("t2_overflow", 32'(overflow_o), 32'(OVF_EXP));
        repeat (4) idleCycle(1'b1);
        applyStimulus(1'b0, '0, '0, 32'hAF, 1'b1, 1'b1);
        waitDone("t2_done");
        checkOutput("t2_overflow_sticky", 32'(overflow_o), 32'(OVF_EXP));
        idleCycle(1'b1);
        for (int i = 0; i < 4; i++) expectWrite(32'h020 + 32'(i), 32'hA0 + 32'(i));
        expectWrite(32'h024, 32'hAF);
        checkLog("t2");

        // Address wrap from all-ones; a fresh start also clears the sticky flag.
        applyStimulus(1'b1, 10'h3FF, 8'd2, 32'h0, 1'b0, 1'b1);
        checkOutput("t3_ovf_cleared", 32'(overflow_o), 32'd0);
        applyStimulus(1'b0, '0, '0, 32'hE1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 32'hE2, 1'b1, 1'b1);
        waitDone("t3_done");
        idleCycle(1'b1);
        expectWrite(32'h3FF, 32'hE1);
        expectWrite(32'h000, 32'hE2);
        checkLog("t3");

        // Zero-length job, then stray results in DONE and IDLE are ignored.
        applyStimulus(1'b1, 10'h077, 8'd0, 32'h0, 1'b0, 1'b1);
        checkOutput("t4_done", 32'(done_o), 32'd1);
        checkOutput("t4_wr_en", 32'(wr_en_o), 32'd0);
        applyStimulus(1'b0, '0, '0, 32'hDD, 1'b1, 1'b1);
        checkOutput("t4_done_pulse", 32'(done_o), 32'd0);
        applyStimulus(1'b0, '0, '0, 32'hDE, 1'b1, 1'b1);
        checkOutput("t4_idle_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("t4_idle_busy", 32'(busy_o), 32'd0);
        checkOutput("t4_idle_ovf", 32'(overflow_o), 32'd0);
        checkLog("t4");

        // Asynchronous reset with two results buffered, then a normal one-element job.
        applyStimulus(1'b1, 10'h100, 8'd4, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 32'hF0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 32'hF1, 1'b1, 1'b0);
        result_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("t5_rst_addr", 32'(wr_addr_o), 32'd0);
        checkOutput("t5_rst_done", 32'(done_o), 32'd0);
        checkOutput("t5_rst_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycle(1'b1);
        checkOutput("t5_post_rst_wr_en", 32'(wr_en_o), 32'd0);
        applyStimulus(1'b1, 10'h050, 8'd1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 32'hC1, 1'b1, 1'b1);
        waitDone("t5_done");
        idleCycle(1'b1);
        expectWrite(32'h050, 32'hC1);
        checkLog("t5");

        // Full buffer with push and accepted pop in the same cycle: nothing may be lost.
        applyStimulus(1'b1, 10'h200, 8'd6, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 32'hB0 + 32'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 32'hB4, 1'b1, 1'b1);
        checkOutput("t6_ovf_pushpop", 32'(overflow_o), 32'd0);
        applyStimulus(1'b0, '0, '0, 32'hB5, 1'b1, 1'b1);
        waitDone("t6_done");
        checkOutput("t6_ovf_end", 32'(overflow_o), 32'd0);
        idleCycle(1'b1);
        for (int i = 0; i < 6; i++) expectWrite(32'h200 + 32'(i), 32'hB0 + 32'(i));
        checkLog("t6");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/vpu_dst_port.md
VPU_DST_PORT -- requirements
Module: vpu_dst_port

Interface
REQ-001 Parameter FIFO_DEPTH, default VPU_PKG::DST_FIFO_DEPTH (4), result buffer entries; SHALL be a power of two and at least 2.
REQ-002 Parameter ADDR_W, default VPU_PKG::SRAM_ADDR_WIDTH, SRAM write-address width.
REQ-003 Parameter CNT_W, default VPU_PKG::ELEM_CNT_WIDTH, element-count width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start_i  in  1  job start pulse; latches dst_addr_i and elem_cnt_i.
REQ-007 dst_addr_i  in  ADDR_W  first SRAM write address of job.
REQ-008 elem_cnt_i  in  CNT_W  number of results expected in job.
REQ-009 result_i  in  VPU_PKG::OPERAND_WIDTH  result from FP execution unit.
REQ-010 result_valid_i  in  1  one-cycle qualifier for result_i (execution unit done strobe).
REQ-011 wr_en_o  out  1  SRAM write request.
REQ-012 wr_addr_o  out  ADDR_W  SRAM write address.
REQ-013 wr_data_o  out  OPERAND_WIDTH  SRAM write data.
REQ-014 wr_ready_i  in  1  SRAM port grant; write accepted when wr_en_o and wr_ready_i high at a clock edge.
REQ-015 busy_o  out  1  high in RUN and DONE states.
REQ-016 done_o  out  1  one-cycle pulse when all elem_cnt writes have been accepted.
REQ-017 overflow_o  out  1  sticky error: result arrived while FIFO full.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE -> RUN on start_i with elem_cnt_i != 0; IDLE -> DONE on start_i with elem_cnt_i == 0.
REQ-019 RUN -> DONE in the cycle after the write that makes accepted-write count equal to latched elem_cnt; DONE -> IDLE unconditionally after one cycle; done_o high only in DONE.
REQ-020 start_i in RUN or DONE SHALL be ignored; result_valid_i in IDLE or DONE SHALL be dropped without setting overflow_o.
REQ-021 In RUN, result_valid_i pushes result_i into the FIFO; earliest wr_en_o for that result is the next cycle (1-cycle minimum latency).
REQ-022 wr_en_o = RUN and FIFO not empty; wr_data_o = FIFO head; FIFO pops on accepted write; wr_en_o, once high, SHALL hold with stable addr/data until accepted.
REQ-023 wr_addr_o starts at latched dst_addr_i, increments by 1 per accepted write, wraps modulo 2^ADDR_W.
REQ-024 Push and pop in the same cycle when full SHALL succeed (no overflow); push when full without pop SHALL drop the result and set overflow_o.
REQ-025 overflow_o clears only on reset or accepted start_i; results pushed beyond elem_cnt remain in FIFO and are flushed on entry to IDLE.
REQ-026 Results SHALL be written in arrival order; no result written twice.

Reset
REQ-027 rst_n low: state IDLE, FIFO empty, counters 0, wr_addr_o 0, wr_en_o/busy_o/done_o/overflow_o 0, asynchronously, including mid-job; no write issued in the first cycle after deassertion.

Configuration
REQ-028 Macro VPU_DST_OVERFLOW_CHK_EN defined: overflow_o behaves per REQ-024/025.
REQ-029 Macro undefined: overflow_o tied 0, sticky flag not built; drop-on-full behaviour unchanged.

Structure
REQ-030 VPU_PKG SHALL hold DST_FIFO_DEPTH, SRAM_ADDR_WIDTH, ELEM_CNT_WIDTH and enum dst_state_t {IDLE, RUN, DONE}.
REQ-031 FIFO SHALL be sub-module vpu_dst_fifo (registered, full/empty, simultaneous push/pop); FSM, counters and address in vpu_dst_port.

Verification
REQ-032 start dst=0x010 cnt=3, three results 1.0/2.0/3.0 back-to-back, wr_ready_i=1 -> writes 0x010/0x011/0x012 in order, done_o one pulse, busy_o low after.
REQ-033 cnt=5, wr_ready_i=0 for 10 cycles, results every 2 cycles -> wr_addr/wr_data held stable, 4 writes buffered, 5th dropped, overflow_o=1 (macro on) / 0 (macro off).
REQ-034 dst=2^ADDR_W-1 cnt=2 -> addresses all-ones then 0.
REQ-035 start cnt=0 -> done_o next cycle, no wr_en_o.
REQ-036 rst_n low mid-job with 2 entries buffered -> all outputs 0 immediately; new start cnt=1 completes normally.
REQ-037 FIFO full, push and accepted pop same cycle -> no drop, overflow_o stays 0.
